param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 104 ++++++++++
 tb/tb_param_sync_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with registered-read or first-word-fall-through output, occupancy
// count, almost-full/almost-empty thresholds and single-cycle overflow/underflow pulses.
module param_sync_fifo #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = 4,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   almost_full,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_THR  = (AW+1)'(DEPTH - AF_LEVEL);
    localparam logic [AW:0] AE_THR  = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] head_w;

    // Extra pointer bit distinguishes full from empty, so all DEPTH entries are usable.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // In FWFT mode rd_valid == !empty, so one acceptance rule serves both modes.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign head_w = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_INC : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + PTR_INC : rd_ptr_q;
        overflow_d  = wr_en && !wr_acc;
        underflow_d = rd_en && !rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; a reset only discards it by rewinding the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data  = empty ? '0 : head_w;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= head_w;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a registered-read instance driven from a vector table and
// scoreboard, and a first-word-fall-through instance driven by hand-written sequences.
module tb_param_sync_fifo;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rd;
        int         cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr0, rd0, wr1, rd1;
    logic [7:0] wd0, wd1;
    logic [7:0] rdat0, rdat1;
    logic       rv0, full0, af0, empty0, ae0, ovf0, unf0;
    logic       rv1, full1, af1, empty1, ae1, ovf1, unf1;
    logic [3:0] cnt0, cnt1;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb0 [$];
    logic [7:0] exp_q [$];
    logic [7:0] last_rd0;
    vec_t       vecs [$];

    always #5 clk = ~clk;

    param_sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .wr_data(wd0), .rd_en(rd0),
        .rd_data(rdat0), .rd_valid(rv0), .full(full0), .almost_full(af0),
        .empty(empty0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0)
    );

    param_sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .wr_data(wd1), .rd_en(rd1),
        .rd_data(rdat1), .rd_valid(rv1), .full(full1), .almost_full(af1),
        .empty(empty1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(logic w, logic [7:0] d, logic r, int c, logic o, logic u);
        vec_t v;
        v.wr = w; v.d = d; v.rd = r; v.cnt = c; v.ovf = o; v.unf = u;
        return v;
    endfunction

    // Expected read data is queued when a read is issued and retired when rd_valid shows.
    task automatic drive0(input logic w, input logic [7:0] d, input logic r);
        logic racc, wacc;
        racc = r && (sb0.size() > 0);
        wacc = w && (sb0.size() < 8);
        if (racc) exp_q.push_back(sb0.pop_front());
        if (wacc) sb0.push_back(d);
        wr0 = w; wd0 = d; rd0 = r;
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b0;
        chk("rd_valid0", 32'(rv0), 32'(racc));
        if (rv0) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid0", 32'(rv0), 32'd0);
            else last_rd0 = exp_q.pop_front();
        end
        chk("rd_data0", 32'(rdat0), 32'(last_rd0));
    endtask

    task automatic drive1(input logic w, input logic [7:0] d, input logic r);
        wr1 = w; wd1 = d; rd1 = r;
        @(posedge clk); #1;
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic chk_flags0(input string tag, input int c);
        chk({tag, "_count"}, 32'(cnt0), 32'(c));
        chk({tag, "_full"}, 32'(full0), 32'(c == 8));
        chk({tag, "_afull"}, 32'(af0), 32'(c >= 6));
        chk({tag, "_empty"}, 32'(empty0), 32'(c == 0));
        chk({tag, "_aempty"}, 32'(ae0), 32'(c <= 1));
    endtask

    initial begin
        wr0 = 0; rd0 = 0; wd0 = 0; wr1 = 0; rd1 = 0; wd1 = 0;
        last_rd0 = 8'h00;

        for (int k = 1; k <= 8; k++) vecs.push_back(mkv(1'b1, 8'(k), 1'b0, k, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 8'h09, 1'b0, 8, 1'b1, 1'b0));
        for (int k = 7; k >= 0; k--) vecs.push_back(mkv(1'b0, 8'h00, 1'b1, k, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 8'h55, 1'b1, 1, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0));

        rst = 1'b1;
        #12;
        chk_flags0("reset", 0);
        chk("reset_rd_valid", 32'(rv0), 32'd0);
        chk("reset_rd_data", 32'(rdat0), 32'd0);
        chk("reset_ovf", 32'(ovf0), 32'd0);
        chk("reset_unf", 32'(unf0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fill, overflow, drain, underflow, write+read at empty.
        for (int i = 0; i < vecs.size(); i++) begin
            drive0(vecs[i].wr, vecs[i].d, vecs[i].rd);
            chk_flags0($sformatf("vec%0d", i), vecs[i].cnt);
            chk($sformatf("vec%0d_ovf", i), 32'(ovf0), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i), 32'(unf0), 32'(vecs[i].unf));
        end

        // Pointer wrap with steady occupancy of three.
        for (int i = 0; i < 3; i++) drive0(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive0(1'b1, 8'(8'h20 + i), 1'b1);
            chk("wrap_count", 32'(cnt0), 32'd3);
        end

        // Write plus read at full: only the read goes through.
        for (int i = 0; i < 5; i++) drive0(1'b1, 8'(8'h40 + i), 1'b0);
        chk("fill_full", 32'(full0), 32'd1);
        drive0(1'b1, 8'h77, 1'b1);
        chk("simfull_count", 32'(cnt0), 32'd7);
        chk("simfull_ovf", 32'(ovf0), 32'd1);
        drive0(1'b0, 8'h00, 1'b1);
        drive0(1'b0, 8'h00, 1'b1);
        chk("prereset_count", 32'(cnt0), 32'd5);

        // Asynchronous reset between clock edges.
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(cnt0), 32'd0);
        chk("midrst_empty", 32'(empty0), 32'd1);
        chk("midrst_rd_valid", 32'(rv0), 32'd0);
        chk("midrst_rd_data", 32'(rdat0), 32'd0);
        #2;
        rst = 1'b0;
        sb0.delete();
        exp_q.delete();
        last_rd0 = 8'h00;
        drive0(1'b1, 8'h3C, 1'b0);
        chk("postrst_empty", 32'(empty0), 32'd0);
        chk("postrst_count", 32'(cnt0), 32'd1);
        drive0(1'b0, 8'h00, 1'b1);
        chk("postrst_data", 32'(rdat0), 32'h3C);

        // First-word-fall-through instance.
        chk("fwft_init_valid", 32'(rv1), 32'd0);
        chk("fwft_init_empty", 32'(empty1), 32'd1);
        drive1(1'b1, 8'hA5, 1'b0);
        chk("fwft_valid", 32'(rv1), 32'd1);
        chk("fwft_data_a5", 32'(rdat1), 32'hA5);
        chk("fwft_count1", 32'(cnt1), 32'd1);
        chk("fwft_aempty", 32'(ae1), 32'd1);
        drive1(1'b1, 8'hB6, 1'b0);
        chk("fwft_head_hold", 32'(rdat1), 32'hA5);
        chk("fwft_count2", 32'(cnt1), 32'd2);
        drive1(1'b0, 8'h00, 1'b1);
        chk("fwft_data_b6", 32'(rdat1), 32'hB6);
        drive1(1'b0, 8'h00, 1'b1);
        chk("fwft_empty", 32'(empty1), 32'd1);
        chk("fwft_valid_low", 32'(rv1), 32'd0);
        chk("fwft_unf_none", 32'(unf1), 32'd0);
        drive1(1'b1, 8'hC7, 1'b1);
        chk("fwft_wr_rd_empty_count", 32'(cnt1), 32'd1);
        chk("fwft_wr_rd_empty_unf", 32'(unf1), 32'd1);
        chk("fwft_data_c7", 32'(rdat1), 32'hC7);
        chk("fwft_ovf", 32'(ovf1), 32'd0);
        chk("fwft_full", 32'(full1), 32'd0);
        chk("fwft_afull", 32'(af1), 32'd0);
        drive1(1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_unf_clear", 32'(unf1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
